cvxif_group_dispatcher: RTL and testbench

- Sits directly upstream of the coprocessor group array and owns the array's command strobes: exec, opcode, instruction id, fill and pick.
- Accepts decoded coprocessor commands from the CV-X-IF issue path over a valid/ready handshake and holds each one in a single-entry register.
- Fires each command to the array only when it is legal: array not busy for an exec, and result credit available.
- Collects pick data and completed-exec data into an in-order result FIFO toward writeback.

---
 rtl/cvxif_group_dispatcher.sv | 216 +++++++++++++++++++++
 tb/tb_cvxif_group_dispatcher.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/cvxif_group_dispatcher.sv
// CV-X-IF command dispatcher: single-entry command holding register, credit-gated
// strobes toward the coprocessor group array, and an in-order result FIFO toward writeback.

module cvxif_group_dispatcher_chk #(
   parameter int CntW        = 3,
   parameter int ResultDepth = 4
) (
   input logic            clk_i,
   input logic            rst_ni,
   input logic            pick_push_i,
   input logic            done_i,
   input logic [CntW-1:0] count_i,
   input logic [1:0]      push_n_i,
   input logic            pop_i
);
   // Protocol and structural invariants of the dispatcher.
   always_ff @(posedge clk_i) begin
      if (rst_ni) begin
         assert (!(pick_push_i && done_i))
            else $error("pick push coincides with group done");
         assert ((int'(count_i) + int'(push_n_i) - int'(pop_i)) <= ResultDepth)
            else $error("result fifo overflow");
      end
   end
endmodule

module cvxif_group_dispatcher #(
   parameter int unsigned XLEN        = 64,
   parameter int unsigned OpcodeWidth = 4,
   parameter int unsigned InIdxWidth  = 3,
   parameter int unsigned OutIdxWidth = 3,
   parameter int unsigned IdWidth     = 4,
   parameter int unsigned ResultDepth = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   issue_valid_i,
   output logic                   issue_ready_o,
   input  logic [1:0]             issue_kind_i,
   input  logic [OpcodeWidth-1:0] issue_opcode_i,
   input  logic [IdWidth-1:0]     issue_id_i,
   input  logic [InIdxWidth-1:0]  issue_in_idx_i,
   input  logic [OutIdxWidth-1:0] issue_out_idx_i,
   input  logic [2*XLEN-1:0]      issue_data_i,
   output logic                   grp_exec_o,
   output logic [OpcodeWidth-1:0] grp_opcode_o,
   output logic [IdWidth-1:0]     grp_instr_id_o,
   output logic                   grp_in_data_vld_o,
   output logic [InIdxWidth-1:0]  grp_in_idx_o,
   output logic [2*XLEN-1:0]      grp_in_data_o,
   output logic                   grp_out_data_vld_o,
   output logic [OutIdxWidth-1:0] grp_out_idx_o,
   input  logic                   grp_busy_i,
   input  logic                   grp_invalid_i,
   input  logic                   grp_done_i,
   input  logic [XLEN-1:0]        grp_out_data_i,
   input  logic [IdWidth-1:0]     grp_instr_id_i,
   output logic                   res_valid_o,
   input  logic                   res_ready_i,
   output logic [IdWidth-1:0]     res_id_o,
   output logic [XLEN-1:0]        res_data_o,
   output logic                   res_exc_o
);
   localparam int PtrW  = $clog2(ResultDepth);
   localparam int CntW  = $clog2(ResultDepth + 1);
   localparam int UsedW = CntW + 1;
   localparam int EntW  = IdWidth + XLEN + 1;
   localparam logic [UsedW-1:0] DepthU = UsedW'(ResultDepth);

   localparam logic [1:0] KIND_FILL      = 2'd0;
   localparam logic [1:0] KIND_EXEC      = 2'd1;
   localparam logic [1:0] KIND_PICK      = 2'd2;
   localparam logic [1:0] KIND_FILL_EXEC = 2'd3;

   typedef enum logic [0:0] {HOLD_EMPTY = 1'b0, HOLD_FULL = 1'b1} hold_state_e;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      if (p == PtrW'(ResultDepth - 1)) ptr_inc = '0;
      else                             ptr_inc = p + PtrW'(1);
   endfunction

   hold_state_e            state_q, state_d;
   logic [1:0]             kind_q;
   logic [OpcodeWidth-1:0] opcode_q;
   logic [IdWidth-1:0]     id_q;
   logic [InIdxWidth-1:0]  in_idx_q;
   logic [OutIdxWidth-1:0] out_idx_q;
   logic [2*XLEN-1:0]      data_q;
   logic [CntW-1:0]        count_q, count_d, outst_q, outst_d;
   logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_ptr1_s;
   logic [EntW-1:0]        mem_q [ResultDepth];

   logic             held_full_s, credit_ok_s, fire_s, accept_s;
   logic             exec_s, fill_s, pick_s, exc_s, pop_s;
   logic [1:0]       push_n_s;
   logic [UsedW-1:0] used_s;
   logic [EntW-1:0]  done_ent_s, exc_ent_s, wr0_ent_s, rd_ent_s;

   assign held_full_s = (state_q == HOLD_FULL);
   assign used_s      = UsedW'(count_q) + UsedW'(outst_q);
   assign credit_ok_s = (used_s < DepthU);

   // Fire decision, group strobes and holding-register next state.
   always_comb begin
      fire_s  = 1'b0;
      exec_s  = 1'b0;
      fill_s  = 1'b0;
      pick_s  = 1'b0;
      exc_s   = 1'b0;
      state_d = state_q;
      if (held_full_s) begin
         if (grp_invalid_i) begin
            fire_s = credit_ok_s;
            exc_s  = credit_ok_s;
         end else begin
            case (kind_q)
               KIND_FILL:      begin fire_s = 1'b1; fill_s = 1'b1; end
               KIND_PICK:      begin fire_s = credit_ok_s; pick_s = credit_ok_s; end
               KIND_EXEC:      begin fire_s = credit_ok_s && !grp_busy_i; exec_s = fire_s; end
               KIND_FILL_EXEC: begin
                  fire_s = credit_ok_s && !grp_busy_i;
                  exec_s = fire_s;
                  fill_s = fire_s;
               end
               default:        fire_s = 1'b0;
            endcase
         end
      end else begin
         fire_s = 1'b0;
      end
      issue_ready_o = !held_full_s || fire_s;
      accept_s      = issue_valid_i && issue_ready_o;
      if (accept_s)    state_d = HOLD_FULL;
      else if (fire_s) state_d = HOLD_EMPTY;
      else             state_d = state_q;
   end

   assign grp_exec_o         = exec_s;
   assign grp_in_data_vld_o  = fill_s;
   assign grp_out_data_vld_o = pick_s;
   assign grp_opcode_o       = held_full_s ? opcode_q  : '0;
   assign grp_instr_id_o     = held_full_s ? id_q      : '0;
   assign grp_in_idx_o       = held_full_s ? in_idx_q  : '0;
   assign grp_in_data_o      = held_full_s ? data_q    : '0;
   assign grp_out_idx_o      = held_full_s ? out_idx_q : '0;

   // Result FIFO bookkeeping; a done entry always lands ahead of a same-cycle exception entry.
   always_comb begin
      done_ent_s = {grp_instr_id_i, grp_out_data_i, 1'b0};
      exc_ent_s  = {id_q, {XLEN{1'b0}}, 1'b1};
      wr0_ent_s  = (exc_s && !grp_done_i) ? exc_ent_s : done_ent_s;
      push_n_s   = {1'b0, grp_done_i} + {1'b0, (pick_s || exc_s)};
      pop_s      = (count_q != '0) && res_ready_i;
      wr_ptr1_s  = ptr_inc(wr_ptr_q);
      count_d    = count_q + CntW'(push_n_s) - CntW'(pop_s);
      outst_d    = outst_q + CntW'(exec_s) - CntW'(grp_done_i);
      rd_ptr_d   = pop_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      case (push_n_s)
         2'd0:    wr_ptr_d = wr_ptr_q;
         2'd1:    wr_ptr_d = wr_ptr1_s;
         2'd2:    wr_ptr_d = ptr_inc(wr_ptr1_s);
         default: wr_ptr_d = wr_ptr_q;
      endcase
   end

   // Holding register, counters and FIFO pointers.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= HOLD_EMPTY;
         kind_q    <= '0;
         opcode_q  <= '0;
         id_q      <= '0;
         in_idx_q  <= '0;
         out_idx_q <= '0;
         data_q    <= '0;
         count_q   <= '0;
         outst_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         outst_q  <= outst_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         if (accept_s) begin
            kind_q    <= issue_kind_i;
            opcode_q  <= issue_opcode_i;
            id_q      <= issue_id_i;
            in_idx_q  <= issue_in_idx_i;
            out_idx_q <= issue_out_idx_i;
            data_q    <= issue_data_i;
         end
      end
   end

   // FIFO storage; contents are masked on the read side while empty, so no reset needed.
   always_ff @(posedge clk_i) begin
      if (rst_ni && (push_n_s != 2'd0)) mem_q[wr_ptr_q]  <= wr0_ent_s;
      if (rst_ni && (push_n_s == 2'd2)) mem_q[wr_ptr1_s] <= exc_ent_s;
   end

   assign rd_ent_s    = mem_q[rd_ptr_q];
   assign res_valid_o = (count_q != '0);
   assign {res_id_o, res_data_o, res_exc_o} = res_valid_o ? rd_ent_s : '0;

   cvxif_group_dispatcher_chk #(.CntW(CntW), .ResultDepth(int'(ResultDepth))) u_chk (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .pick_push_i (pick_s),
      .done_i      (grp_done_i),
      .count_i     (count_q),
      .push_n_i    (push_n_s),
      .pop_i       (pop_s)
   );
endmodule

// File: tb/tb_cvxif_group_dispatcher.sv
// Directed self-checking bench for cvxif_group_dispatcher; the group array is modelled
// by bench-driven busy/done/data signals and an opcode range check (8 groups).
module tb_cvxif_group_dispatcher;
   localparam int XLEN = 64;

   logic             clk_i = 1'b0;
   logic             rst_ni;
   logic             issue_valid_i, issue_ready_o;
   logic [1:0]       issue_kind_i;
   logic [3:0]       issue_opcode_i, issue_id_i;
   logic [2:0]       issue_in_idx_i, issue_out_idx_i;
   logic [2*XLEN-1:0] issue_data_i;
   logic             grp_exec_o, grp_in_data_vld_o, grp_out_data_vld_o;
   logic [3:0]       grp_opcode_o, grp_instr_id_o;
   logic [2:0]       grp_in_idx_o, grp_out_idx_o;
   logic [2*XLEN-1:0] grp_in_data_o;
   logic             grp_busy_i, grp_invalid_i, grp_done_i;
   logic [XLEN-1:0]  grp_out_data_i;
   logic [3:0]       grp_instr_id_i;
   logic             res_valid_o, res_ready_i, res_exc_o;
   logic [3:0]       res_id_o;
   logic [XLEN-1:0]  res_data_o;

   int total = 0;
   int bad   = 0;

   always #5 clk_i = ~clk_i;
   assign grp_invalid_i = (grp_opcode_o >= 4'd8);

   cvxif_group_dispatcher dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
      .issue_kind_i(issue_kind_i), .issue_opcode_i(issue_opcode_i),
      .issue_id_i(issue_id_i), .issue_in_idx_i(issue_in_idx_i),
      .issue_out_idx_i(issue_out_idx_i), .issue_data_i(issue_data_i),
      .grp_exec_o(grp_exec_o), .grp_opcode_o(grp_opcode_o),
      .grp_instr_id_o(grp_instr_id_o), .grp_in_data_vld_o(grp_in_data_vld_o),
      .grp_in_idx_o(grp_in_idx_o), .grp_in_data_o(grp_in_data_o),
      .grp_out_data_vld_o(grp_out_data_vld_o), .grp_out_idx_o(grp_out_idx_o),
      .grp_busy_i(grp_busy_i), .grp_invalid_i(grp_invalid_i),
      .grp_done_i(grp_done_i), .grp_out_data_i(grp_out_data_i),
      .grp_instr_id_i(grp_instr_id_i),
      .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
      .res_id_o(res_id_o), .res_data_o(res_data_o), .res_exc_o(res_exc_o)
   );

   // Drives a command at the next falling edge, waits (bounded) for acceptance,
   // and returns at the falling edge after the accepting rising edge with valid dropped.
   task automatic issue(input logic [1:0] kind, input logic [3:0] op, input logic [3:0] id,
                        input logic [2:0] in_idx, input logic [2:0] out_idx);
      int n = 0;
      @(negedge clk_i);
      issue_valid_i = 1'b1; issue_kind_i = kind; issue_opcode_i = op; issue_id_i = id;
      issue_in_idx_i = in_idx; issue_out_idx_i = out_idx;
      #1;
      while (!issue_ready_o && n < 20) begin @(negedge clk_i); #1; n++; end
      total++; if (issue_ready_o !== 1'b1) begin bad++; $display("FAIL issue_accept: ready=%b want 1 within 20 cycles", issue_ready_o); end
      @(negedge clk_i);
      issue_valid_i = 1'b0;
   endtask

   task automatic test_reset;
      rst_ni = 1'b0; issue_valid_i = 1'b0; issue_kind_i = 2'd0; issue_opcode_i = 4'd0;
      issue_id_i = 4'd0; issue_in_idx_i = 3'd0; issue_out_idx_i = 3'd0; issue_data_i = '0;
      grp_busy_i = 1'b0; grp_done_i = 1'b0; grp_out_data_i = '0; grp_instr_id_i = 4'd0;
      res_ready_i = 1'b0;
      repeat (2) @(negedge clk_i);
      #1;
      total++; if (issue_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", issue_ready_o); end
      total++; if (res_valid_o !== 1'b0) begin bad++; $display("FAIL reset_res_valid: got %b want 0", res_valid_o); end
      total++; if ({grp_exec_o, grp_in_data_vld_o, grp_out_data_vld_o} !== 3'b000) begin bad++; $display("FAIL reset_strobes: got %b want 000", {grp_exec_o, grp_in_data_vld_o, grp_out_data_vld_o}); end
      total++; if (grp_opcode_o !== 4'd0) begin bad++; $display("FAIL reset_opcode: got %0h want 0", grp_opcode_o); end
      rst_ni = 1'b1;
   endtask

   task automatic test_fill;
      @(negedge clk_i);
      issue_valid_i = 1'b1; issue_kind_i = 2'd0; issue_opcode_i = 4'd1; issue_id_i = 4'd0;
      issue_in_idx_i = 3'd2; issue_data_i = {64'h11, 64'h22};
      #1;
      total++; if (grp_in_data_vld_o !== 1'b0) begin bad++; $display("FAIL fill_early: got %b want 0", grp_in_data_vld_o); end
      @(negedge clk_i);
      issue_valid_i = 1'b0;
      #1;
      total++; if (grp_in_data_vld_o !== 1'b1) begin bad++; $display("FAIL fill_strobe: got %b want 1", grp_in_data_vld_o); end
      total++; if (grp_in_idx_o !== 3'd2) begin bad++; $display("FAIL fill_idx: got %0d want 2", grp_in_idx_o); end
      total++; if (grp_in_data_o !== {64'h11, 64'h22}) begin bad++; $display("FAIL fill_data: got %0h want 11_22", grp_in_data_o); end
      total++; if (issue_ready_o !== 1'b1) begin bad++; $display("FAIL fill_ready: got %b want 1", issue_ready_o); end
      @(negedge clk_i); #1;
      total++; if (grp_in_data_vld_o !== 1'b0) begin bad++; $display("FAIL fill_one_cycle: got %b want 0", grp_in_data_vld_o); end
      total++; if (res_valid_o !== 1'b0) begin bad++; $display("FAIL fill_no_result: got %b want 0", res_valid_o); end
   endtask

   task automatic test_exec_stall;
      grp_busy_i = 1'b1;
      issue(2'd1, 4'd0, 4'd5, 3'd0, 3'd0);
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if ({grp_exec_o, issue_ready_o} !== 2'b00) begin bad++; $display("FAIL exec_stall: exec,ready=%b want 00 cycle %0d", {grp_exec_o, issue_ready_o}, i); end
         @(negedge clk_i);
      end
      grp_busy_i = 1'b0;
      #1;
      total++; if ({grp_exec_o, issue_ready_o} !== 2'b11) begin bad++; $display("FAIL exec_fire: exec,ready=%b want 11", {grp_exec_o, issue_ready_o}); end
      total++; if (grp_instr_id_o !== 4'd5) begin bad++; $display("FAIL exec_id: got %0d want 5", grp_instr_id_o); end
      @(negedge clk_i); #1;
      total++; if (grp_exec_o !== 1'b0) begin bad++; $display("FAIL exec_one_cycle: got %b want 0", grp_exec_o); end
      grp_done_i = 1'b1; grp_out_data_i = 64'hABCD; grp_instr_id_i = 4'd5;
      #1;
      total++; if (res_valid_o !== 1'b0) begin bad++; $display("FAIL done_no_fallthrough: got %b want 0", res_valid_o); end
      @(negedge clk_i);
      grp_done_i = 1'b0;
      #1;
      total++; if ({res_valid_o, res_id_o, res_data_o, res_exc_o} !== {1'b1, 4'd5, 64'hABCD, 1'b0}) begin bad++; $display("FAIL done_result: v=%b id=%0d data=%0h exc=%b want 1/5/abcd/0", res_valid_o, res_id_o, res_data_o, res_exc_o); end
      res_ready_i = 1'b1;
      @(negedge clk_i);
      res_ready_i = 1'b0;
      #1;
      total++; if (res_valid_o !== 1'b0) begin bad++; $display("FAIL done_pop: got %b want 0", res_valid_o); end
   endtask

   task automatic test_pick;
      issue(2'd2, 4'd0, 4'd0, 3'd0, 3'd1);
      grp_out_data_i = 64'h77; grp_instr_id_i = 4'd3;
      #1;
      total++; if ({grp_out_data_vld_o, grp_out_idx_o} !== {1'b1, 3'd1}) begin bad++; $display("FAIL pick_strobe: vld=%b idx=%0d want 1/1", grp_out_data_vld_o, grp_out_idx_o); end
      @(negedge clk_i); #1;
      total++; if (grp_out_data_vld_o !== 1'b0) begin bad++; $display("FAIL pick_one_cycle: got %b want 0", grp_out_data_vld_o); end
      total++; if ({res_valid_o, res_id_o, res_data_o, res_exc_o} !== {1'b1, 4'd3, 64'h77, 1'b0}) begin bad++; $display("FAIL pick_result: v=%b id=%0d data=%0h exc=%b want 1/3/77/0", res_valid_o, res_id_o, res_data_o, res_exc_o); end
      res_ready_i = 1'b1;
      @(negedge clk_i);
      res_ready_i = 1'b0;
   endtask

   task automatic test_invalid;
      issue(2'd1, 4'd9, 4'd7, 3'd0, 3'd0);
      #1;
      total++; if ({grp_exec_o, grp_in_data_vld_o, grp_out_data_vld_o} !== 3'b000) begin bad++; $display("FAIL inv_strobes: got %b want 000", {grp_exec_o, grp_in_data_vld_o, grp_out_data_vld_o}); end
      total++; if ({grp_opcode_o, issue_ready_o} !== {4'd9, 1'b1}) begin bad++; $display("FAIL inv_fire: op=%0d ready=%b want 9/1", grp_opcode_o, issue_ready_o); end
      @(negedge clk_i); #1;
      total++; if ({res_valid_o, res_id_o, res_data_o, res_exc_o} !== {1'b1, 4'd7, 64'h0, 1'b1}) begin bad++; $display("FAIL inv_result: v=%b id=%0d data=%0h exc=%b want 1/7/0/1", res_valid_o, res_id_o, res_data_o, res_exc_o); end
      res_ready_i = 1'b1;
      @(negedge clk_i);
      res_ready_i = 1'b0;
   endtask

   task automatic test_done_exc_order;
      issue(2'd1, 4'd0, 4'd2, 3'd0, 3'd0);
      issue(2'd1, 4'd9, 4'd6, 3'd0, 3'd0);
      grp_done_i = 1'b1; grp_out_data_i = 64'h55; grp_instr_id_i = 4'd2;
      #1;
      total++; if (issue_ready_o !== 1'b1) begin bad++; $display("FAIL order_fire: ready=%b want 1", issue_ready_o); end
      @(negedge clk_i);
      grp_done_i = 1'b0;
      #1;
      total++; if ({res_valid_o, res_id_o, res_data_o, res_exc_o} !== {1'b1, 4'd2, 64'h55, 1'b0}) begin bad++; $display("FAIL order_first: v=%b id=%0d data=%0h exc=%b want 1/2/55/0", res_valid_o, res_id_o, res_data_o, res_exc_o); end
      res_ready_i = 1'b1;
      @(negedge clk_i); #1;
      total++; if ({res_valid_o, res_id_o, res_data_o, res_exc_o} !== {1'b1, 4'd6, 64'h0, 1'b1}) begin bad++; $display("FAIL order_second: v=%b id=%0d data=%0h exc=%b want 1/6/0/1", res_valid_o, res_id_o, res_data_o, res_exc_o); end
      @(negedge clk_i);
      res_ready_i = 1'b0;
      #1;
      total++; if (res_valid_o !== 1'b0) begin bad++; $display("FAIL order_drained: got %b want 0", res_valid_o); end
   endtask

   task automatic test_credit;
      for (int i = 0; i < 4; i++) issue(2'd1, 4'(i), 4'(i), 3'd0, 3'd0);
      issue(2'd1, 4'd0, 4'd4, 3'd0, 3'd0);
      #1;
      total++; if ({grp_exec_o, issue_ready_o} !== 2'b00) begin bad++; $display("FAIL credit_block: exec,ready=%b want 00", {grp_exec_o, issue_ready_o}); end
      @(negedge clk_i);
      grp_done_i = 1'b1; grp_out_data_i = 64'h100; grp_instr_id_i = 4'd0;
      #1;
      total++; if (grp_exec_o !== 1'b0) begin bad++; $display("FAIL credit_done_only: got %b want 0", grp_exec_o); end
      @(negedge clk_i);
      grp_done_i = 1'b0;
      #1;
      total++; if ({grp_exec_o, res_valid_o, res_id_o} !== {1'b0, 1'b1, 4'd0}) begin bad++; $display("FAIL credit_queued: exec=%b v=%b id=%0d want 0/1/0", grp_exec_o, res_valid_o, res_id_o); end
      res_ready_i = 1'b1;
      @(negedge clk_i);
      res_ready_i = 1'b0;
      #1;
      total++; if ({grp_exec_o, grp_instr_id_o} !== {1'b1, 4'd4}) begin bad++; $display("FAIL credit_release: exec=%b id=%0d want 1/4", grp_exec_o, grp_instr_id_o); end
      for (int i = 1; i < 5; i++) begin
         @(negedge clk_i);
         grp_done_i = 1'b1; grp_out_data_i = 64'(i); grp_instr_id_i = 4'(i); res_ready_i = 1'b1;
         #1;
         if (i >= 2) begin
            total++; if ({res_valid_o, res_id_o} !== {1'b1, 4'(i - 1)}) begin bad++; $display("FAIL credit_drain: v=%b id=%0d want 1/%0d", res_valid_o, res_id_o, i - 1); end
         end
      end
      @(negedge clk_i);
      grp_done_i = 1'b0;
      repeat (2) @(negedge clk_i);
      res_ready_i = 1'b0;
   endtask

   task automatic test_back_to_back;
      issue(2'd2, 4'd0, 4'd0, 3'd0, 3'd0);
      grp_out_data_i = 64'h99; grp_instr_id_i = 4'd1;
      @(negedge clk_i); #1;
      total++; if (res_valid_o !== 1'b1) begin bad++; $display("FAIL b2b_queued: got %b want 1", res_valid_o); end
      issue_valid_i = 1'b1; issue_kind_i = 2'd0; issue_opcode_i = 4'd1; issue_in_idx_i = 3'd0;
      for (int i = 1; i < 6; i++) begin
         @(negedge clk_i);
         issue_in_idx_i = 3'(i);
         #1;
         total++; if ({grp_in_data_vld_o, grp_in_idx_o, issue_ready_o} !== {1'b1, 3'(i - 1), 1'b1}) begin bad++; $display("FAIL b2b_fill: vld=%b idx=%0d ready=%b want 1/%0d/1", grp_in_data_vld_o, grp_in_idx_o, issue_ready_o, i - 1); end
      end
      @(negedge clk_i);
      rst_ni = 1'b0;
      @(negedge clk_i); #1;
      total++; if ({grp_exec_o, grp_in_data_vld_o, grp_out_data_vld_o, res_valid_o} !== 4'b0000) begin bad++; $display("FAIL b2b_reset: exec,fill,pick,res=%b want 0000", {grp_exec_o, grp_in_data_vld_o, grp_out_data_vld_o, res_valid_o}); end
      issue_valid_i = 1'b0;
      rst_ni = 1'b1;
      @(negedge clk_i);
   endtask

   initial begin
      test_reset();
      test_fill();
      test_exec_stall();
      test_pick();
      test_invalid();
      test_done_exc_order();
      test_credit();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
